// File: rtl/icache_data_if.sv
// Read-request/response and refill-beat handshake bundle
// for the icache data-array controller.
interface icache_data_if;
  logic         rd_req_valid;
  logic [5:0]   rd_req_index;
  logic         rd_req_ready;
  logic         rd_resp_valid;
  logic [127:0] rd_resp_data;
  logic         fill_valid;
  logic [5:0]   fill_index;
  logic [63:0]  fill_data;
  logic         fill_ready;

  modport master (
    output rd_req_valid,
    output rd_req_index,
    input  rd_req_ready,
    input  rd_resp_valid,
    input  rd_resp_data,
    output fill_valid,
    output fill_index,
    output fill_data,
    input  fill_ready
  );

  modport slave (
    input  rd_req_valid,
    input  rd_req_index,
    output rd_req_ready,
    output rd_resp_valid,
    output rd_resp_data,
    input  fill_valid,
    input  fill_index,
    input  fill_data,
    output fill_ready
  );
endinterface

// File: rtl/icache_data_ctrl.sv
// Icache data-array controller: power-on zeroing, two-beat
// refill and pipelined reads into a 64x128 single-port SRAM.
module icache_data_ctrl (
  input  logic           clk,
  input  logic           rst,
  icache_data_if.slave   bus,
  output logic           init_done,
  output logic           sram_csb,
  output logic           sram_web,
  output logic [1:0]     sram_wmask,
  output logic [5:0]     sram_addr,
  output logic [127:0]   sram_din,
  input  logic [127:0]   sram_dout
);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_FILL_HI
  } state_e;

  state_e         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [5:0]     fidx_q, fidx_d;
  logic           csb_q, csb_d;
  logic           web_q, web_d;
  logic [1:0]     wmask_q, wmask_d;
  logic [5:0]     addr_q, addr_d;
  logic [127:0]   din_q, din_d;
  logic           v1_q, v1_d;
  logic           v2_q, v2_d;
  logic           rv_q, rv_d;
  logic [127:0]   rdata_q, rdata_d;
  logic           done_q, done_d;
  logic           rd_fire;
  logic           fill_fire;

  assign bus.rd_req_ready =
    (state_q == S_IDLE) && !bus.fill_valid;
  assign bus.fill_ready =
    (state_q == S_IDLE) || (state_q == S_FILL_HI);

  assign rd_fire   = bus.rd_req_valid && bus.rd_req_ready;
  assign fill_fire = bus.fill_valid && bus.fill_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fidx_d  = fidx_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = 2'b00;
    addr_d  = addr_q;
    din_d   = din_q;
    // dout is valid the cycle after the SRAM captures the read
    v1_d    = rd_fire;
    v2_d    = v1_q;
    rv_d    = v2_q;
    rdata_d = v2_q ? sram_dout : rdata_q;
    done_d  = done_q | (state_q == S_IDLE);
    unique case (state_q)
      S_INIT: begin
        csb_d   = 1'b0;
        web_d   = 1'b0;
        wmask_d = 2'b11;
        addr_d  = cnt_q;
        din_d   = '0;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'd63)
          state_d = S_IDLE;
      end
      S_IDLE: begin
        unique case (1'b1)
          fill_fire: begin
            fidx_d  = bus.fill_index;
            csb_d   = 1'b0;
            web_d   = 1'b0;
            wmask_d = 2'b01;
            addr_d  = bus.fill_index;
            din_d   = {bus.fill_data, bus.fill_data};
            state_d = S_FILL_HI;
          end
          rd_fire: begin
            csb_d  = 1'b0;
            addr_d = bus.rd_req_index;
          end
          default: ;
        endcase
      end
      S_FILL_HI: begin
        if (fill_fire) begin
          csb_d   = 1'b0;
          web_d   = 1'b0;
          wmask_d = 2'b10;
          addr_d  = fidx_q;
          din_d   = {bus.fill_data, bus.fill_data};
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      fidx_q  <= '0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= 2'b00;
      addr_q  <= '0;
      din_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fidx_q  <= fidx_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  assign sram_csb          = csb_q;
  assign sram_web          = web_q;
  assign sram_wmask        = wmask_q;
  assign sram_addr         = addr_q;
  assign sram_din          = din_q;
  assign bus.rd_resp_valid = rv_q;
  assign bus.rd_resp_data  = rdata_q;
  assign init_done         = done_q;

endmodule

// File: tb/tb_icache_data_ctrl.sv
// Randomized scoreboard bench for icache_data_ctrl with a
// behavioural SRAM and line-array reference model.
module tb_icache_data_ctrl;

  logic         clk;
  logic         rst;
  logic         init_done;
  logic         sram_csb;
  logic         sram_web;
  logic [1:0]   sram_wmask;
  logic [5:0]   sram_addr;
  logic [127:0] sram_din;
  logic [127:0] sram_dout;

  icache_data_if bus ();

  icache_data_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .init_done  (init_done),
    .sram_csb   (sram_csb),
    .sram_web   (sram_web),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: capture on rising edge, write/read on the following falling edge
  logic [127:0] mem [64];
  logic         cap_en, cap_we;
  logic [1:0]   cap_m;
  logic [5:0]   cap_a;
  logic [127:0] cap_d;

  initial begin
    for (int i = 0; i < 64; i++)
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
    sram_dout = '0;
    cap_en = 1'b0;
  end

  always @(posedge clk) begin
    cap_en <= !sram_csb;
    cap_we <= !sram_web;
    cap_m  <= sram_wmask;
    cap_a  <= sram_addr;
    cap_d  <= sram_din;
  end

  always @(negedge clk) begin
    if (cap_en) begin
      if (cap_we) begin
        if (cap_m[0]) mem[cap_a][63:0]   = cap_d[63:0];
        if (cap_m[1]) mem[cap_a][127:64] = cap_d[127:64];
      end else begin
        sram_dout = mem[cap_a];
      end
    end
  end

  // reference model: line contents plus expected responses
  typedef struct {
    logic [127:0] d;
    int           c;
  } exp_t;

  exp_t         q[$];
  logic [127:0] ref_mem [64];
  logic         in_hi;
  logic [5:0]   hi_idx;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rd_resp_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected cyc=%0d data=%0h",
                 cyc, bus.rd_resp_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.d !== bus.rd_resp_data || e.c != cyc) begin
          fails++;
          $display("FAIL resp actual=%0h@%0d required=%0h@%0d",
                   bus.rd_resp_data, cyc, e.d, e.c);
        end
      end
    end
  end

  // called at a falling edge; returns at the next falling edge
  task automatic cycle(input logic rv, input logic [5:0] ri,
                       input logic fv, input logic [5:0] fi,
                       input logic [63:0] fd);
    logic racc, facc;
    logic [5:0] widx;
    bus.rd_req_valid = rv;
    bus.rd_req_index = ri;
    bus.fill_valid   = fv;
    bus.fill_index   = fi;
    bus.fill_data    = fd;
    #1;
    chk("ready", {bus.rd_req_ready, bus.fill_ready},
        {!fv && !in_hi, 1'b1});
    racc = rv && !fv && !in_hi;
    facc = fv;
    widx = in_hi ? hi_idx : fi;
    if (facc) begin
      if (in_hi) ref_mem[widx][127:64] = fd;
      else       ref_mem[widx][63:0]   = fd;
    end
    if (racc) q.push_back('{ref_mem[ri], cyc + 3});
    @(posedge clk);
    #1;
    if (facc && in_hi)
      chk("fill_hi_op",
          {sram_csb, sram_web, sram_wmask, sram_addr, sram_din},
          {1'b0, 1'b0, 2'b10, widx, fd, fd});
    else if (facc)
      chk("fill_lo_op",
          {sram_csb, sram_web, sram_wmask, sram_addr, sram_din},
          {1'b0, 1'b0, 2'b01, widx, fd, fd});
    else if (racc)
      chk("rd_op", {sram_csb, sram_web, sram_addr},
          {1'b0, 1'b1, ri});
    else
      chk("idle_op", {sram_csb, sram_web, sram_wmask},
          {1'b1, 1'b1, 2'b00});
    if (facc) begin
      if (!in_hi) hi_idx = fi;
      in_hi = !in_hi;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 6'd0, 1'b0, 6'd0, 64'd0);
  endtask

  task automatic do_reset(input int n_init);
    rst = 1'b1;
    bus.rd_req_valid = 1'b0;
    bus.fill_valid   = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_state",
        {sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
         bus.rd_resp_valid, bus.rd_resp_data, init_done},
        {1'b1, 1'b1, 2'b00, 6'd0, 128'd0, 1'b0, 128'd0, 1'b0});
    q.delete();
    in_hi = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < n_init; i++) begin
      @(posedge clk);
      #1;
      chk("init_wr",
          {sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
           init_done},
          {1'b0, 1'b0, 2'b11, 6'(i), 128'd0, 1'b0});
    end
    if (n_init == 64) begin
      @(posedge clk);
      #1;
      chk("init_done", {init_done, sram_csb}, {1'b1, 1'b1});
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_hi = 1'b0;
    hi_idx = '0;
    bus.rd_req_valid = 1'b0;
    bus.rd_req_index = '0;
    bus.fill_valid   = 1'b0;
    bus.fill_index   = '0;
    bus.fill_data    = '0;

    do_reset(64);
    cycle(1'b1, 6'd5, 1'b0, 6'd0, 64'd0);
    idle(3);

    cycle(1'b0, 6'd0, 1'b1, 6'h2A, 64'h1111_1111_1111_1111);
    cycle(1'b0, 6'd0, 1'b1, 6'h00, 64'h2222_2222_2222_2222);
    cycle(1'b1, 6'h2A, 1'b0, 6'd0, 64'd0);
    idle(3);
    chk("line_2a", ref_mem[6'h2A],
        {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    cycle(1'b1, 6'd1, 1'b0, 6'd0, 64'd0);
    cycle(1'b1, 6'd2, 1'b0, 6'd0, 64'd0);
    cycle(1'b1, 6'd3, 1'b0, 6'd0, 64'd0);
    idle(3);

    cycle(1'b1, 6'd9, 1'b1, 6'd9, 64'hDEAD_BEEF_0000_0001);
    cycle(1'b1, 6'd9, 1'b1, 6'd7, 64'hCAFE_F00D_0000_0002);
    cycle(1'b1, 6'd9, 1'b0, 6'd0, 64'd0);
    idle(3);

    for (int i = 0; i < 800; i++) begin
      logic fv, rv;
      logic [5:0] ri, fi;
      fv = in_hi ? ($urandom_range(0, 9) < 7)
                 : ($urandom_range(0, 9) < 2);
      rv = $urandom_range(0, 9) < 6;
      ri = $urandom_range(0, 1) ? 6'($urandom_range(0, 7))
                                : 6'($urandom_range(0, 63));
      fi = $urandom_range(0, 1) ? 6'($urandom_range(0, 7))
                                : 6'($urandom_range(0, 63));
      cycle(rv, ri, fv, fi, {$urandom, $urandom});
    end
    if (in_hi)
      cycle(1'b0, 6'd0, 1'b1, 6'd0, {$urandom, $urandom});
    idle(4);
    chk("drain", q.size(), 0);

    // read in flight and fill half-done when reset hits
    cycle(1'b1, 6'd3, 1'b0, 6'd0, 64'd0);
    cycle(1'b0, 6'd0, 1'b1, 6'd3, 64'h5555_AAAA_5555_AAAA);
    do_reset(20);
    do_reset(64);
    cycle(1'b1, 6'd3, 1'b0, 6'd0, 64'd0);
    cycle(1'b1, 6'h2A, 1'b0, 6'd0, 64'd0);
    cycle(1'b1, 6'd9, 1'b0, 6'd0, 64'd0);
    idle(4);
    chk("drain_rst", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/icache_data_ctrl.md
ICACHE_DATA_CTRL -- requirements
Module: icache_data_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the only clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port rd_req_valid, input, 1, read request present.
REQ-004 SHALL have port rd_req_index, input, 6, line index to read.
REQ-005 SHALL have port rd_req_ready, output, 1, read request accepted this cycle when high with rd_req_valid.
REQ-006 SHALL have port rd_resp_valid, output, 1, one-cycle pulse, rd_resp_data valid.
REQ-007 SHALL have port rd_resp_data, output, 128, returned line; holds until next response.
REQ-008 SHALL have port fill_valid, input, 1, refill beat present.
REQ-009 SHALL have port fill_index, input, 6, line index; sampled on beat 0 only.
REQ-010 SHALL have port fill_data, input, 64, beat data; beat 0 = bits [63:0], beat 1 = bits [127:64].
REQ-011 SHALL have port fill_ready, output, 1, beat accepted when high with fill_valid.
REQ-012 SHALL have port init_done, output, 1, high once power-on zeroing completes.
REQ-013 SHALL have ports sram_csb (out, 1, active-low select), sram_web (out, 1, active-low write), sram_wmask (out, 2, per-64-bit-half write enable), sram_addr (out, 6), sram_din (out, 128), sram_dout (in, 128), driving a 64x128 single-port SRAM with 64-bit write granularity.

Function
REQ-014 All sram_* outputs SHALL be registered; an op driven after edge N is captured by the SRAM at edge N+1.
REQ-015 Idle cycles SHALL drive sram_csb=1, sram_web=1, sram_wmask=00; sram_addr/sram_din hold previous value.
REQ-016 States SHALL be INIT, IDLE, FILL_HI.
REQ-017 INIT: 6-bit counter 0..63, one write per cycle: csb=0, web=0, wmask=11, addr=counter, din=0; after addr 63 issued -> IDLE, init_done=1 next cycle and stays 1 until reset.
REQ-018 rd_req_ready SHALL be combinational: (state==IDLE) && !fill_valid; fill_ready SHALL be (state==IDLE || state==FILL_HI).
REQ-019 Fill has priority over read when both valid in IDLE.
REQ-020 Beat 0 accepted in IDLE: latch fill_index; issue write addr=fill_index, din={fill_data,fill_data}, wmask=01; -> FILL_HI.
REQ-021 Beat 1 accepted in FILL_HI: issue write addr=latched index, din={fill_data,fill_data}, wmask=10; -> IDLE; fill_index ignored. No reads accepted in FILL_HI.
REQ-022 Read accepted at edge N: issue csb=0, web=1, addr=rd_req_index; capture sram_dout into rd_resp_data at edge N+2; rd_resp_valid=1 for the cycle following edge N+2.
REQ-023 Reads SHALL be fully pipelined: one accept per cycle, responses in acceptance order, no bubbles; 2-stage in-flight valid tracking.
REQ-024 A read accepted the cycle after a write to the same index SHALL return post-write data (SRAM writes on falling edge of capture cycle).
REQ-025 Only one SRAM op SHALL be issued per cycle; write and read never coincide.

Reset
REQ-026 On rst: state=INIT, counter=0, sram_csb=1, sram_web=1, sram_wmask=00, sram_addr=0, sram_din=0, rd_resp_valid=0, rd_resp_data=0, init_done=0, in-flight reads and latched fill index discarded.
REQ-027 Reset mid-INIT SHALL restart zeroing at addr 0; reset mid-fill (in FILL_HI) SHALL drop the pending beat 1 and re-zero the array; reset with reads in flight SHALL emit no rd_resp_valid.

Verification
REQ-028 Deassert rst -> 64 consecutive cycles csb=0, web=0, wmask=11, addr 0..63, din=0; init_done=1 next cycle; read index 5 -> rd_resp_data=0.
REQ-029 Fill index 6'h2A beats 64'h1111_1111_1111_1111 then 64'h2222_2222_2222_2222 -> wmask 01 then 10 at addr 2A; read 2A -> rd_resp_data=128'h2222..._1111..., rd_resp_valid two edges after accept.
REQ-030 Reads to indices 1,2,3 in consecutive cycles -> rd_resp_valid high three consecutive cycles, data of 1,2,3 in order.
REQ-031 fill_valid and rd_req_valid both high in IDLE -> fill_ready=1, rd_req_ready=0; read accepted only in the cycle after beat 1 accepted.
REQ-032 rst asserted in FILL_HI and with a read in flight -> no rd_resp_valid, INIT restarts at addr 0, init_done=0.
REQ-033 Read of index X issued the cycle after beat 1 to X -> returns full new line.
